x3q16_mem_responder: RTL and testbench
======================================

Name: x3q16_mem_responder

Overview:
- Memory-side responder for the x3q16 core's request bus.
- Accepts one-cycle request pulses (read or write), services them from an internal synchronous word array after a fixed latency, and returns single-cycle memory_ready / write_complete pulses.
- Drives memory_critical on out-of-range accesses.
- Provides a side preload port that the bench and boot logic use to fill program memory before the core runs.

Parameters:
- ADDR_BITS, 10, array depth is 2**ADDR_BITS 16-bit words; valid addresses are 0 .. 2**ADDR_BITS-1.
- READ_LATENCY, 2, clock edges from request sample to memory_ready assertion; legal range 1..15.
- WRITE_LATENCY, 2, clock edges from request sample to write commit and write_complete assertion; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- request  in  1  one-cycle request strobe from core.
- request_type  in  1  0 = read, 1 = write; qualified by request.
- request_address  in  16  word address; qualified by request.
- data_in  in  16  write data (core data_out); qualified by request.
- rdata  out  16  read data (to core memory_in); valid while memory_ready is high.
- memory_ready  out  1  one-cycle read-response pulse.
- write_complete  out  1  one-cycle write-done pulse.
- memory_critical  out  1  one-cycle pulse, coincident with the response, on out-of-range access.
- busy  out  1  high while a transaction is outstanding.
- overrun  out  1  sticky; set when a request arrives while busy.
- load_en  in  1  preload write strobe.
- load_addr  in  ADDR_BITS  preload address.
- load_data  in  16  preload data.
- load_ready  out  1  high when a preload is accepted this cycle.

Behaviour:
- Clock and reset: clk rising edge; reset asynchronous, active-high.
- Reset values:
  - rdata = 0, memory_ready = 0, write_complete = 0, memory_critical = 0, busy = 0, overrun = 0.
  - FSM to IDLE, latency counter = 0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On request = 1 at an edge, capture request_type, request_address and data_in.
  - Load the counter with READ_LATENCY-1 or WRITE_LATENCY-1 for the selected type.
  - If that value is 0, go to RESP; otherwise go to WAIT.
  - busy goes high on the same edge.
- WAIT: decrement the counter each edge; on reaching 0, go to RESP.
- RESP (exactly one cycle, then IDLE; busy drops on exit):
  - Read: rdata <= array[addr]; memory_ready = 1.
  - Write: array[addr] <= captured data; write_complete = 1.
  - memory_ready and write_complete are never both high.
- Latency: with a request sampled at edge k, the response pulse is high during the cycle after edge k+LATENCY. With latency 1, the response appears in the cycle right after the request cycle.
- Out of range (request_address[15:ADDR_BITS] != 0):
  - A response is still generated so the core never hangs.
  - Read returns 16'h0000; write is discarded.
  - memory_critical pulses in the same cycle as memory_ready / write_complete.
- rdata holds its last read value until the next read response. Writes do not change rdata.
- Request while busy (WAIT or RESP):
  - The request is ignored and the in-flight transaction is unaffected.
  - overrun is set and stays set until reset.
- A request on the same edge that RESP exits to IDLE counts as busy, so it is dropped and flagged. The core only re-requests after seeing the response, so this never happens in normal operation.
- Preload:
  - load_ready = (state == IDLE) && !request.
  - When load_en && load_ready: array[load_addr] <= load_data at the edge.
  - A preload is never accepted in the same cycle as a request sample.
  - load_en while not ready is dropped; the source must hold load_en until load_ready.
- Read-after-write to the same address returns the new data: the write commits at its RESP edge, before any later read's RESP.
- Reset mid-transaction:
  - The pending operation is aborted and no array write occurs.
  - Outputs go to reset values; no response pulse is produced afterwards.
- Array is inferred synchronous single-port; only RESP and preload access it, and they are mutually exclusive.

Test Plan:
- Preload: array[0] = 16'h1234, array[1] = 16'hABCD via the load port; read addr 0 with READ_LATENCY = 2 -> memory_ready high exactly one cycle, two edges after the request edge, with rdata = 16'h1234; busy high for 2 cycles.
- Write then read: write 16'h5A5A to addr 3 -> write_complete one-cycle pulse at WRITE_LATENCY; then read addr 3 -> rdata = 16'h5A5A; memory_critical stays 0 throughout.
- Out of range (ADDR_BITS = 10): read addr 16'h0400 -> memory_ready with rdata = 16'h0000 plus a memory_critical pulse; write addr 16'hFFFF -> write_complete plus memory_critical; array[16'h03FF] unchanged.
- Overrun: second request one cycle after the first, different address -> first response correct, second gets no response; overrun = 1 and still 1 after 10 idle cycles.
- Reset mid-write: request write 16'hBEEF to addr 5, assert reset one cycle later -> no write_complete; after reset, read addr 5 returns its prior value.
- Back-to-back fetch loop: drive the core's fetch pattern (request, wait for ready, request at next+1) across addresses 0..7 with READ_LATENCY = 1 -> eight memory_ready pulses, each with the correct word, and overrun = 0.

Source files
------------

// File: rtl/x3q16_mem_responder.sv
// Memory-side responder for the x3q16 request bus: fixed-latency read/write
// service from a synchronous word array, with a side preload port.
module x3q16_mem_responder #(
  parameter int ADDR_BITS     = 10,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 request,
  input  logic                 request_type,
  input  logic [15:0]          request_address,
  input  logic [15:0]          data_in,
  output logic [15:0]          rdata,
  output logic                 memory_ready,
  output logic                 write_complete,
  output logic                 memory_critical,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [15:0]          load_data,
  output logic                 load_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

  state_t               state;
  logic [3:0]           count;
  logic                 op_write;
  logic                 op_oor;
  logic [ADDR_BITS-1:0] op_addr;
  logic [15:0]          op_data;
  logic [3:0]           lat_load;
  logic                 oor_req;

  logic [15:0] mem [2**ADDR_BITS];

  assign lat_load   = request_type ? WR_LOAD : RD_LOAD;
  assign oor_req    = request_address[15:ADDR_BITS] != '0;
  assign load_ready = (state == IDLE) && !request;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      count           <= '0;
      op_write        <= 1'b0;
      op_oor          <= 1'b0;
      op_addr         <= '0;
      op_data         <= '0;
      rdata           <= '0;
      memory_ready    <= 1'b0;
      write_complete  <= 1'b0;
      memory_critical <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      memory_ready    <= 1'b0;
      write_complete  <= 1'b0;
      memory_critical <= 1'b0;
      // Any request outside IDLE (including the RESP exit edge) is dropped.
      if (request && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (request) begin
            op_write <= request_type;
            op_oor   <= oor_req;
            op_addr  <= request_address[ADDR_BITS-1:0];
            op_data  <= data_in;
            count    <= lat_load;
            busy     <= 1'b1;
            state    <= (lat_load == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) state <= RESP;
        end
        RESP: begin
          state           <= IDLE;
          busy            <= 1'b0;
          memory_critical <= op_oor;
          if (op_write) begin
            write_complete <= 1'b1;
          end else begin
            memory_ready <= 1'b1;
            rdata        <= op_oor ? '0 : mem[op_addr];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single array port: RESP and preload can never coincide since load_ready needs IDLE.
  always_ff @(posedge clk) begin
    if (state == RESP && op_write && !op_oor)
      mem[op_addr] <= op_data;
    else if (load_en && load_ready)
      mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_x3q16_mem_responder.sv
// Randomized self-checking bench: two responder instances with different
// latencies share one stimulus stream and are checked against an array model.
module tb_x3q16_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        request;
  logic        request_type;
  logic [15:0] request_address;
  logic [15:0] data_in;
  logic        load_en;
  logic [9:0]  load_addr;
  logic [15:0] load_data;

  logic [15:0] rdata [2];
  logic        memory_ready [2];
  logic        write_complete [2];
  logic        memory_critical [2];
  logic        busy [2];
  logic        overrun [2];
  logic        load_ready [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model
  logic [15:0] mem_model [1024];
  logic [15:0] last_rd [2];
  bit          ovr_model;
  int          rl [2] = '{2, 1};
  int          wl [2] = '{2, 3};
  localparam int WIN = 8;

  always #5 clk = ~clk;

  x3q16_mem_responder #(.ADDR_BITS(10), .READ_LATENCY(2), .WRITE_LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .request(request), .request_type(request_type),
    .request_address(request_address), .data_in(data_in), .rdata(rdata[0]),
    .memory_ready(memory_ready[0]), .write_complete(write_complete[0]),
    .memory_critical(memory_critical[0]), .busy(busy[0]), .overrun(overrun[0]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready[0])
  );

  x3q16_mem_responder #(.ADDR_BITS(10), .READ_LATENCY(1), .WRITE_LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .request(request), .request_type(request_type),
    .request_address(request_address), .data_in(data_in), .rdata(rdata[1]),
    .memory_ready(memory_ready[1]), .write_complete(write_complete[1]),
    .memory_critical(memory_critical[1]), .busy(busy[1]), .overrun(overrun[1]),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_rdata"}, 32'(rdata[i]), 32'(last_rd[i]));
      check({tag, "_ready"}, 32'(memory_ready[i]), 32'd0);
      check({tag, "_wc"}, 32'(write_complete[i]), 32'd0);
      check({tag, "_crit"}, 32'(memory_critical[i]), 32'd0);
      check({tag, "_busy"}, 32'(busy[i]), 32'd0);
      check({tag, "_overrun"}, 32'(overrun[i]), 32'(ovr_model));
    end
  endtask

  // One transaction observed for WIN cycles after its sampling edge.
  // ovr_try re-requests one cycle later; load_try pushes a preload into the busy window.
  task automatic txn(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                     input bit ovr_try, input bit load_try);
    bit          oor;
    logic [15:0] exp_rd;
    int          lat;
    bit          resp;
    oor    = addr[15:10] != 6'd0;
    exp_rd = oor ? 16'h0000 : mem_model[addr[9:0]];
    @(negedge clk);
    request         = 1'b1;
    request_type    = wr;
    request_address = addr;
    data_in         = data;
    load_en         = load_try;
    load_addr       = 10'h3FF;
    load_data       = 16'($urandom);
    for (int n = 1; n <= WIN; n++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        lat  = wr ? wl[i] : rl[i];
        resp = (n == lat + 1);
        if (resp && !wr) last_rd[i] = exp_rd;
        check("busy", 32'(busy[i]), 32'(n <= lat));
        check("memory_ready", 32'(memory_ready[i]), 32'(resp && !wr));
        check("write_complete", 32'(write_complete[i]), 32'(resp && wr));
        check("memory_critical", 32'(memory_critical[i]), 32'(resp && oor));
        check("rdata", 32'(rdata[i]), 32'(last_rd[i]));
        check("load_ready", 32'(load_ready[i]), 32'((n > lat) && !request));
      end
      if (n == 1 && ovr_try) begin
        request_type    = 1'b1;
        request_address = addr + 16'd1;
        data_in         = ~data;
        ovr_model       = 1'b1;
      end else begin
        request = 1'b0;
      end
      if (n != 1) load_en = 1'b0;
    end
    if (wr && !oor) mem_model[addr[9:0]] = data;
    for (int i = 0; i < 2; i++) check("overrun", 32'(overrun[i]), 32'(ovr_model));
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 16'($urandom_range(16'h0400, 16'hFFFF));
    return 16'($urandom_range(0, 1023));
  endfunction

  initial begin
    reset = 1'b1; request = 1'b0; request_type = 1'b0; request_address = '0;
    data_in = '0; load_en = 1'b0; load_addr = '0; load_data = '0;
    last_rd = '{16'h0, 16'h0}; ovr_model = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Preload the whole array
    for (int a = 0; a < 1024; a++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) check("preload_ready", 32'(load_ready[i]), 32'd1);
      load_en   = 1'b1;
      load_addr = 10'(a);
      load_data = (a == 0) ? 16'h1234 : (a == 1) ? 16'hABCD : 16'($urandom);
      mem_model[a] = load_data;
    end
    @(negedge clk);
    load_en = 1'b0;

    txn(1'b0, 16'h0000, 16'h0, 1'b0, 1'b0);
    check("preload_word0", 32'(rdata[0]), 32'h1234);
    txn(1'b0, 16'h0001, 16'h0, 1'b0, 1'b0);
    check("preload_word1", 32'(rdata[1]), 32'hABCD);
    txn(1'b1, 16'h0003, 16'h5A5A, 1'b0, 1'b0);
    txn(1'b0, 16'h0003, 16'h0, 1'b0, 1'b0);
    check("raw_word3", 32'(rdata[0]), 32'h5A5A);
    txn(1'b0, 16'h0400, 16'h0, 1'b0, 1'b0);
    txn(1'b1, 16'hFFFF, 16'hDEAD, 1'b0, 1'b0);
    txn(1'b0, 16'h03FF, 16'h0, 1'b0, 1'b0);

    // Random traffic, occasionally racing a preload against a request
    for (int t = 0; t < 200; t++)
      txn(1'($urandom_range(0, 1)), rand_addr(), 16'($urandom), 1'b0,
          $urandom_range(0, 9) == 0);
    txn(1'b0, 16'h03FF, 16'h0, 1'b0, 1'b0);

    // Overrun: second request dropped, flag sticky
    txn(1'b0, 16'h0010, 16'h7777, 1'b1, 1'b0);
    txn(1'b0, 16'h0011, 16'h0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 2; i++) check("overrun_sticky", 32'(overrun[i]), 32'd1);

    // Reset one cycle into a write: no commit, no response
    @(negedge clk);
    request = 1'b1; request_type = 1'b1; request_address = 16'h0005; data_in = 16'hBEEF;
    @(negedge clk);
    request = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_rd = '{16'h0, 16'h0};
    ovr_model = 1'b0;
    for (int n = 0; n < WIN; n++) begin
      @(negedge clk);
      check_idle_outputs("post_reset");
    end
    txn(1'b0, 16'h0005, 16'h0, 1'b0, 1'b0);

    // Fetch loop
    for (int a = 0; a < 8; a++) txn(1'b0, 16'(a), 16'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
